hazard_forward_ctrl: RTL and testbench

//  Pipeline controller for the EX stage of the 5-stage MIPS datapath.

---
 rtl/hazard_forward_ctrl_pkg.sv | 35 +++
 rtl/hazard_forward_ctrl_forward_unit.sv | 26 ++
 rtl/hazard_forward_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard/forwarding controller:
// forward select encodings, FSM state encodings and the forwarding
// priority function used by forward_unit.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM stage result

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_MC_BUSY = 1'b1
    } state_t;

    // Select the newest in-flight producer of src_reg. MEM is younger than
    // WB, so it wins; register $0 is hardwired to zero and never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic       mem_reg_write,
        input logic [4:0] mem_write_reg,
        input logic       wb_reg_write,
        input logic [4:0] wb_write_reg,
        input logic [4:0] src_reg
    );
        logic [1:0] sel;
        if (mem_reg_write && (mem_write_reg != 5'd0) && (mem_write_reg == src_reg)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == src_reg)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_forward_unit.sv
// forward_unit: combinational EX operand forwarding selects.
// Ports:
//   EX_Rs, EX_Rt                  source registers of the instruction in EX
//   MEM_RegWrite, MEM_WriteReg    producer in MEM
//   WB_RegWrite, WB_WriteReg      producer in WB
//   ForwardA, ForwardB            operand A/B select (FWD_REG/FWD_WB/FWD_MEM)
module forward_unit
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [4:0] EX_Rs,
    input  logic [4:0] EX_Rt,
    input  logic       MEM_RegWrite,
    input  logic [4:0] MEM_WriteReg,
    input  logic       WB_RegWrite,
    input  logic [4:0] WB_WriteReg,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);

    // Operand selects for both EX source operands.
    always_comb begin
        ForwardA = fwd_select(MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg, EX_Rs);
        ForwardB = fwd_select(MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg, EX_Rt);
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX-stage pipeline controller for the 5-stage MIPS pipe.
// Produces operand forwarding selects, load-use stalls, taken-branch flushes
// and freezes the front of the pipe while a multi-cycle op occupies EX.
// Ports:
//   Clk, Reset (sync, active-high)
//   ID_* / EX_* / MEM_* / WB_*   register fields and control bits per stage
//   BranchTaken                  branch resolved taken
//   PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, IFID_Flush
//                                pipeline register enables / bubbles / flush
//   ForwardA, ForwardB           EX operand selects
//   MultiBusy, MultiDone         multi-cycle op status
//   StallCount                   saturating count of cycles with PCWrite=0
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic [4:0]  EX_Rs,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteReg,
    input  logic        EX_MultiStart,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        EXMEM_Bubble,
    output logic        IFID_Flush,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic        MultiBusy,
    output logic        MultiDone,
    output logic [31:0] StallCount
);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        stall_count_r;
    logic               lu_s;

    forward_unit u_forward_unit (
        .EX_Rs        (EX_Rs),
        .EX_Rt        (EX_Rt),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_WriteReg (MEM_WriteReg),
        .WB_RegWrite  (WB_RegWrite),
        .WB_WriteReg  (WB_WriteReg),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB)
    );

    // Load-use hazard: the load in EX cannot forward in time to ID's consumer.
    always_comb begin
        lu_s = EX_MemRead && (EX_WriteReg != 5'd0) &&
               ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                (ID_UsesRt && (ID_Rt == EX_WriteReg)));
    end

    // Pipeline enables, bubbles and flushes decoded from state and hazards.
    always_comb begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        IFID_Flush   = 1'b0;
        MultiBusy    = 1'b0;
        MultiDone    = 1'b0;
        case (state_r)
            S_RUN: begin
                // The flush squashes the stalled consumer anyway, so it wins.
                if (BranchTaken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                end else if (lu_s) begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end else begin
                    IDEX_Bubble = 1'b0;
                end
            end
            S_MC_BUSY: begin
                // EX is held; MEM receives NOPs until the op completes.
                PCWrite      = 1'b0;
                IFID_Write   = 1'b0;
                IDEX_Write   = 1'b0;
                EXMEM_Bubble = 1'b1;
                MultiBusy    = 1'b1;
                if (cnt_r == CNT_W'(1)) begin
                    MultiDone = 1'b1;
                end else begin
                    MultiDone = 1'b0;
                end
            end
            default: begin
                PCWrite = 1'b1;
            end
        endcase
    end

    // FSM, busy counter and saturating stall counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= S_RUN;
            cnt_r         <= '0;
            stall_count_r <= 32'd0;
        end else begin
            case (state_r)
                S_RUN: begin
                    // First op cycle runs in RUN, so only MULT_CYCLES-1 busy cycles follow.
                    if (EX_MultiStart) begin
                        state_r <= S_MC_BUSY;
                        cnt_r   <= CNT_W'(MULT_CYCLES - 1);
                    end
                end
                S_MC_BUSY: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= S_RUN;
                    end
                end
                default: begin
                    state_r <= S_RUN;
                    cnt_r   <= '0;
                end
            endcase
            if (!PCWrite && (stall_count_r != 32'hFFFF_FFFF)) begin
                stall_count_r <= stall_count_r + 32'd1;
            end
        end
    end

    assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed, table-driven bench for hazard_forward_ctrl (MULT_CYCLES=4).
module tb_hazard_forward_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_WriteReg, MEM_WriteReg, WB_WriteReg;
    logic        ID_UsesRs, ID_UsesRt, EX_MemRead, EX_MultiStart;
    logic        MEM_RegWrite, WB_RegWrite, BranchTaken;
    logic        PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, IFID_Flush;
    logic [1:0]  ForwardA, ForwardB;
    logic        MultiBusy, MultiDone;
    logic [31:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall;

    always #5 Clk = ~Clk;

    hazard_forward_ctrl #(.MULT_CYCLES(4), .CNT_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .EX_MultiStart(EX_MultiStart),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
        .IDEX_Bubble(IDEX_Bubble), .EXMEM_Bubble(EXMEM_Bubble), .IFID_Flush(IFID_Flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MultiBusy(MultiBusy), .MultiDone(MultiDone), .StallCount(StallCount)
    );

    typedef struct packed {
        logic [4:0] id_rs;  logic [4:0] id_rt;  logic id_urs; logic id_urt;
        logic [4:0] ex_rs;  logic [4:0] ex_rt;  logic ex_mr;  logic [4:0] ex_wr;
        logic mem_rw; logic [4:0] mem_wr; logic wb_rw; logic [4:0] wb_wr;
        logic br;
        logic [1:0] fa; logic [1:0] fb;
        logic pcw; logic ifidw; logic bub; logic flush;
    } vec_t;

    vec_t vecs[10];

    // {PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, IFID_Flush, MultiBusy, MultiDone}
    function automatic logic [7:0] ctrl_of();
        return {PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, EXMEM_Bubble, IFID_Flush, MultiBusy, MultiDone};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
        EX_Rs = 5'd0; EX_Rt = 5'd0; EX_MemRead = 1'b0; EX_WriteReg = 5'd0;
        EX_MultiStart = 1'b0; MEM_RegWrite = 1'b0; MEM_WriteReg = 5'd0;
        WB_RegWrite = 1'b0; WB_WriteReg = 5'd0; BranchTaken = 1'b0;
    endtask

    initial begin
        vec_t v;
        //            idrs   idrt  urs  urt  exrs   exrt   mr   exwr   mrw  memwr  wrw  wbwr   br   fa     fb     pcw  ifw  bub  fl
        vecs[0] = '{5'd0,  5'd0,  1'b0,1'b0,5'd8,  5'd3,  1'b0,5'd0,  1'b1,5'd8,  1'b1,5'd8,  1'b0,2'b10, 2'b00, 1'b1,1'b1,1'b0,1'b0};
        vecs[1] = '{5'd0,  5'd0,  1'b0,1'b0,5'd8,  5'd3,  1'b0,5'd0,  1'b0,5'd8,  1'b1,5'd8,  1'b0,2'b01, 2'b00, 1'b1,1'b1,1'b0,1'b0};
        vecs[2] = '{5'd0,  5'd0,  1'b0,1'b0,5'd0,  5'd0,  1'b0,5'd0,  1'b1,5'd0,  1'b1,5'd0,  1'b0,2'b00, 2'b00, 1'b1,1'b1,1'b0,1'b0};
        vecs[3] = '{5'd0,  5'd0,  1'b0,1'b0,5'd6,  5'd5,  1'b0,5'd0,  1'b1,5'd5,  1'b1,5'd6,  1'b0,2'b01, 2'b10, 1'b1,1'b1,1'b0,1'b0};
        vecs[4] = '{5'd0,  5'd9,  1'b0,1'b1,5'd1,  5'd2,  1'b1,5'd9,  1'b0,5'd0,  1'b0,5'd0,  1'b0,2'b00, 2'b00, 1'b0,1'b0,1'b1,1'b0};
        vecs[5] = '{5'd0,  5'd9,  1'b0,1'b1,5'd1,  5'd2,  1'b1,5'd9,  1'b0,5'd0,  1'b0,5'd0,  1'b1,2'b00, 2'b00, 1'b1,1'b1,1'b1,1'b1};
        vecs[6] = '{5'd4,  5'd9,  1'b1,1'b0,5'd1,  5'd2,  1'b1,5'd9,  1'b0,5'd0,  1'b0,5'd0,  1'b0,2'b00, 2'b00, 1'b1,1'b1,1'b0,1'b0};
        vecs[7] = '{5'd0,  5'd0,  1'b1,1'b1,5'd1,  5'd2,  1'b1,5'd0,  1'b0,5'd0,  1'b0,5'd0,  1'b0,2'b00, 2'b00, 1'b1,1'b1,1'b0,1'b0};
        vecs[8] = '{5'd12, 5'd3,  1'b1,1'b0,5'd12, 5'd12, 1'b1,5'd12, 1'b1,5'd12, 1'b0,5'd0,  1'b0,2'b10, 2'b10, 1'b0,1'b0,1'b1,1'b0};
        vecs[9] = '{5'd12, 5'd3,  1'b1,1'b0,5'd7,  5'd12, 1'b0,5'd12, 1'b0,5'd12, 1'b1,5'd7,  1'b1,2'b01, 2'b00, 1'b1,1'b1,1'b1,1'b1};

        // Reset state
        clear_inputs();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("reset_ctrl", 32'(ctrl_of()), 32'h0000_00E0);
        check("reset_fwd", {28'd0, ForwardA, ForwardB}, 32'd0);
        check("reset_stall", StallCount, 32'd0);
        exp_stall = 0;

        // Table of single-cycle vectors in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            v = vecs[i];
            ID_Rs = v.id_rs; ID_Rt = v.id_rt; ID_UsesRs = v.id_urs; ID_UsesRt = v.id_urt;
            EX_Rs = v.ex_rs; EX_Rt = v.ex_rt; EX_MemRead = v.ex_mr; EX_WriteReg = v.ex_wr;
            MEM_RegWrite = v.mem_rw; MEM_WriteReg = v.mem_wr;
            WB_RegWrite = v.wb_rw; WB_WriteReg = v.wb_wr; BranchTaken = v.br;
            #1;
            check($sformatf("vec%0d_fwdA", i), 32'(ForwardA), 32'(v.fa));
            check($sformatf("vec%0d_fwdB", i), 32'(ForwardB), 32'(v.fb));
            check($sformatf("vec%0d_ctrl", i), 32'(ctrl_of()),
                  32'({v.pcw, v.ifidw, 1'b1, v.bub, 1'b0, v.flush, 1'b0, 1'b0}));
            check($sformatf("vec%0d_stall", i), StallCount, 32'(exp_stall));
            if (!v.pcw) exp_stall++;
        end
        @(negedge Clk);
        clear_inputs();
        #1;
        check("stall_after_table", StallCount, 32'(exp_stall));

        // Clear counter, then a multi-cycle op (MULT_CYCLES=4)
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("stall_cleared", StallCount, 32'd0);
        @(negedge Clk);
        EX_MultiStart = 1'b1;   // first op cycle, still in RUN
        #1;
        check("mc_issue_ctrl", 32'(ctrl_of()), 32'h0000_00E0);
        @(negedge Clk);         // busy 1: MultiStart held high must be ignored
        #1;
        check("mc_b1_ctrl", 32'(ctrl_of()), 32'h0000_000A);
        check("mc_b1_stall", StallCount, 32'd0);
        @(negedge Clk);         // busy 2: branch and load-use are ignored
        EX_MultiStart = 1'b0;
        BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_WriteReg = 5'd9; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
        #1;
        check("mc_b2_ctrl", 32'(ctrl_of()), 32'h0000_000A);
        check("mc_b2_stall", StallCount, 32'd1);
        @(negedge Clk);         // busy 3: last cycle
        clear_inputs();
        #1;
        check("mc_b3_ctrl", 32'(ctrl_of()), 32'h0000_000B);
        check("mc_b3_stall", StallCount, 32'd2);
        @(negedge Clk);
        #1;
        check("mc_end_ctrl", 32'(ctrl_of()), 32'h0000_00E0);
        check("mc_end_stall", StallCount, 32'd3);

        // Reset during the 2nd busy cycle aborts the op without MultiDone
        @(negedge Clk);
        EX_MultiStart = 1'b1;
        @(negedge Clk);
        EX_MultiStart = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort_b2_ctrl", 32'(ctrl_of()), 32'h0000_000A);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("abort_ctrl", 32'(ctrl_of()), 32'h0000_00E0);
        check("abort_stall", StallCount, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            #1;
            check($sformatf("abort_idle%0d", k), {30'd0, MultiBusy, MultiDone}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
